wb_delay_line: RTL and testbench
================================

# wb_delay_line

Parametrised writeback delay line with operand forwarding. It carries the writeback triple (RegWEn, AddrD, DataD) through DEPTH register stages before the register file is written. The in-flight stages can be searched by two read ports, so decode/execute can bypass values that are not yet committed. It sits between the writeback mux and the register file.

## Interface
- DEPTH, 2, number of delay stages (1..8); end-to-end latency in cycles
- DATA_W, 32, writeback data width
- ADDR_W, 5, register address width
- CNT_W, $clog2(DEPTH+1), width of pend_cnt (localparam)

Ports:
- clk  in  1  single clock; everything samples on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold all stages; the input triple is not captured
- flush  in  1  invalidate every stage at the next edge
- RegWEn  in  1  write enable of the incoming writeback
- AddrD  in  ADDR_W  destination register of the incoming writeback
- DataD  in  DATA_W  data of the incoming writeback
- RegWEn_out  out  1  write enable to the register file (last stage)
- AddrD_out  out  ADDR_W  destination to the register file
- DataD_out  out  DATA_W  data to the register file
- rs1_addr, rs2_addr  in  ADDR_W  forwarding lookup addresses
- fwd1_hit, fwd2_hit  out  1  a valid in-flight write matches rsN_addr
- fwd1_data, fwd2_data  out  DATA_W  data of the youngest match; 0 when there is no hit
- pend_cnt  out  CNT_W  number of valid stages

## Operation
- Each stage k holds {v_k, a_k, d_k}. Stage 0 is the youngest; stage DEPTH-1 drives the *_out ports.
- On capture, v_0 <= RegWEn && (AddrD != 0). Writes to x0 are dropped at entry and never forward.
- When neither stall nor flush is asserted, stage 0 takes the input and stage k takes stage k-1.
- When stall is asserted and flush is not, every stage holds and the input is ignored. RegWEn_out stays at its held value. Repeated identical register-file writes are acceptable.
- flush clears every v_k at the next edge. a_k and d_k may keep their old values.
- If flush and stall are both asserted, flush wins.
- Forwarding is combinational. It searches stages 0..DEPTH-1 and the lowest-index valid stage with a_k == rsN_addr wins.
- rsN_addr == 0 always gives hit = 0 and data = 0.
- The two read ports are independent and may hit the same or different stages.
- pend_cnt is a registered count of the set v_k bits after each edge. It is maintained incrementally: +1 on entry, −1 on exit, 0 on flush.

## Timing
- Reset (asynchronous): every v_k, a_k, d_k and pend_cnt is cleared to 0. RegWEn_out = 0, AddrD_out = 0, DataD_out = 0, all fwd outputs = 0.
- Latency: an input captured at edge n appears on the *_out ports after edge n+DEPTH-1, i.e. DEPTH cycles, if no stall occurs. Each stalled cycle adds one cycle.
- Forwarding sees a value from the cycle after capture until it leaves the last stage.
- The same-cycle input is not forwarded.
- Reset mid-operation drops all in-flight writes with no register-file write.
- Flush in the same cycle as a valid input: the input is discarded as well.

## Configuration
- WB_DELAY_FWD_EN: when defined, the forwarding comparators and priority mux are built as above.
- When not defined, fwd1_hit, fwd2_hit, fwd1_data and fwd2_data are tied to 0, rsN_addr are unused, and the delay-line and pend_cnt behaviour is unchanged.

## Test plan
- Reset, then DEPTH=2, input {1, 5'd3, 32'hDEAD_BEEF} for one cycle → *_out = {1, 3, DEADBEEF} exactly two cycles later and 0 before; pend_cnt goes 1, 1, 0 around the exit.
- Back-to-back writes to x7 (32'h11) then x7 (32'h22), rs1_addr = 7 → fwd1_data = 32'h11 in the first cycle, then 32'h22 (youngest wins); fwd1_hit = 1 until both entries retire.
- Write to x0 with RegWEn = 1, data 32'hFFFF_FFFF → RegWEn_out never asserts, pend_cnt stays 0, and rs1_addr = 0 gives hit 0 and data 0.
- Stall held for 3 cycles with one entry in stage 0 → the entry stays put and the output appears three cycles late; a new input presented during the stall is lost.
- Two valid entries in flight, assert flush together with stall → next cycle pend_cnt = 0, all hits are 0, and RegWEn_out stays 0 for DEPTH cycles.
- Assert reset_n low asynchronously mid-cycle with full stages → all outputs are 0 immediately, before the next clk edge.
- Build without WB_DELAY_FWD_EN → the fwd outputs stay 0 in every scenario above and delay-line results are identical.

Source files
------------

// File: rtl/wb_delay_line_if.sv
// Bus interface for wb_delay_line: writeback triple in, register-file
// triple out, forwarding lookup ports and pending-write count.
// The producer/consumer side (writeback mux, decode, bench) uses the
// master modport; the delay line itself uses the slave modport.
interface wb_delay_line_if #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Pipeline control
  logic              stall;
  logic              flush;

  // Incoming writeback
  logic              RegWEn;
  logic [ADDR_W-1:0] AddrD;
  logic [DATA_W-1:0] DataD;

  // Register-file write (oldest stage)
  logic              RegWEn_out;
  logic [ADDR_W-1:0] AddrD_out;
  logic [DATA_W-1:0] DataD_out;

  // Forwarding lookup
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;

  // Number of valid in-flight writes
  logic [CNT_W-1:0]  pend_cnt;

  modport master (
    output stall, flush, RegWEn, AddrD, DataD, rs1_addr, rs2_addr,
    input  RegWEn_out, AddrD_out, DataD_out,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, pend_cnt
  );

  modport slave (
    input  stall, flush, RegWEn, AddrD, DataD, rs1_addr, rs2_addr,
    output RegWEn_out, AddrD_out, DataD_out,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data, pend_cnt
  );
endinterface

// File: rtl/wb_delay_line.sv
// wb_delay_line: carries the writeback triple (RegWEn, AddrD, DataD)
// through DEPTH register stages before it reaches the register file.
// Stage 0 is the youngest, stage DEPTH-1 drives the register-file port.
// In-flight stages can be searched by two read ports so decode/execute
// can bypass values that are not yet committed.
//
// Optional feature macro: WB_DELAY_FWD_EN
//   defined   -> forwarding comparators and priority mux are built
//   undefined -> fwd*_hit / fwd*_data are tied to 0, rs*_addr unused
//
// Writes to x0 are dropped at entry, so they never occupy a valid stage,
// never forward and never reach the register file.
module wb_delay_line #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  wb_delay_line_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Per-stage state
  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  v_d;
  logic [ADDR_W-1:0] a_q [DEPTH];
  logic [ADDR_W-1:0] a_d [DEPTH];
  logic [DATA_W-1:0] d_q [DEPTH];
  logic [DATA_W-1:0] d_d [DEPTH];
  logic [CNT_W-1:0]  pend_cnt_q;
  logic [CNT_W-1:0]  pend_cnt_d;

  // Entry qualification and pipeline movement
  logic              in_vld;
  logic              advance;

  // A write enters only if enabled and not aimed at x0; flush beats stall
  always_comb begin
    in_vld  = bus.RegWEn && (bus.AddrD != '0);
    advance = !bus.flush && !bus.stall;
  end

  // Next-state for all stages: shift on advance, clear valids on flush,
  // otherwise hold (address/data are left untouched by flush)
  always_comb begin
    v_d = v_q;
    for (int k = 0; k < DEPTH; k++) begin
      a_d[k] = a_q[k];
      d_d[k] = d_q[k];
    end
    if (bus.flush) begin
      v_d = '0;
    end else if (advance) begin
      v_d[0] = in_vld;
      a_d[0] = bus.AddrD;
      d_d[0] = bus.DataD;
      for (int k = 1; k < DEPTH; k++) begin
        v_d[k] = v_q[k-1];
        a_d[k] = a_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
  end

  // Incremental occupancy: +1 for a valid entry, -1 for a valid exit
  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (bus.flush) begin
      pend_cnt_d = '0;
    end else if (advance) begin
      pend_cnt_d = pend_cnt_q + CNT_W'(in_vld) - CNT_W'(v_q[DEPTH-1]);
    end
  end

  // Stage registers and occupancy counter, cleared by asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q        <= '0;
      pend_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        a_q[k] <= '0;
        d_q[k] <= '0;
      end
    end else begin
      v_q        <= v_d;
      pend_cnt_q <= pend_cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        a_q[k] <= a_d[k];
        d_q[k] <= d_d[k];
      end
    end
  end

  // Register-file port is the oldest stage
  always_comb begin
    bus.RegWEn_out = v_q[DEPTH-1];
    bus.AddrD_out  = a_q[DEPTH-1];
    bus.DataD_out  = d_q[DEPTH-1];
    bus.pend_cnt   = pend_cnt_q;
  end

`ifdef WB_DELAY_FWD_EN
  // Priority search per read port: scan oldest to youngest so the
  // lowest-index (youngest) matching valid stage is the one that sticks
  always_comb begin
    bus.fwd1_hit  = 1'b0;
    bus.fwd1_data = '0;
    bus.fwd2_hit  = 1'b0;
    bus.fwd2_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v_q[k] && (a_q[k] == bus.rs1_addr) && (bus.rs1_addr != '0)) begin
        bus.fwd1_hit  = 1'b1;
        bus.fwd1_data = d_q[k];
      end
      if (v_q[k] && (a_q[k] == bus.rs2_addr) && (bus.rs2_addr != '0)) begin
        bus.fwd2_hit  = 1'b1;
        bus.fwd2_data = d_q[k];
      end
    end
  end
`else
  logic unused_rs;

  // Forwarding not built: lookup ports are ignored and outputs held at 0
  always_comb begin
    unused_rs     = ^{bus.rs1_addr, bus.rs2_addr};
    bus.fwd1_hit  = 1'b0;
    bus.fwd1_data = '0;
    bus.fwd2_hit  = 1'b0;
    bus.fwd2_data = '0;
  end
`endif

endmodule

// File: tb/tb_wb_delay_line.sv
// Testbench for wb_delay_line: directed scenarios followed by a random
// phase, all checked against a queue-based reference model of in-flight
// writes. Forwarding expectations follow WB_DELAY_FWD_EN.
module tb_wb_delay_line;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  ent_t pipe [$];

  wb_delay_line_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifc ();

  wb_delay_line #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z.v = 1'b0; z.a = '0; z.d = '0;
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back(z);
  endtask

  // One clock edge of the reference: writes queue up, oldest falls off
  task automatic model_edge();
    ent_t e;
    if (ifc.flush) begin
      foreach (pipe[k]) pipe[k].v = 1'b0;
    end else if (!ifc.stall) begin
      e.v = ifc.RegWEn && (ifc.AddrD != 0);
      e.a = ifc.AddrD;
      e.d = ifc.DataD;
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
  endtask

  task automatic model_fwd(input logic [ADDR_W-1:0] rs, output logic hit,
                           output logic [DATA_W-1:0] data);
    hit = 1'b0;
    data = '0;
`ifdef WB_DELAY_FWD_EN
    if (rs != 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (pipe[k].v && pipe[k].a == rs) begin
          hit = 1'b1;
          data = pipe[k].d;
          break;
        end
      end
    end
`endif
  endtask

  task automatic check_all(input string tag);
    int cnt;
    logic h;
    logic [DATA_W-1:0] dv;
    cnt = 0;
    foreach (pipe[k]) if (pipe[k].v) cnt++;
    chk({tag, ".wen"}, DATA_W'(ifc.RegWEn_out), DATA_W'(pipe[DEPTH-1].v));
    if (pipe[DEPTH-1].v) begin
      chk({tag, ".addr"}, DATA_W'(ifc.AddrD_out), DATA_W'(pipe[DEPTH-1].a));
      chk({tag, ".data"}, ifc.DataD_out, pipe[DEPTH-1].d);
    end
    chk({tag, ".pend"}, DATA_W'(ifc.pend_cnt), DATA_W'(cnt));
    model_fwd(ifc.rs1_addr, h, dv);
    chk({tag, ".hit1"}, DATA_W'(ifc.fwd1_hit), DATA_W'(h));
    chk({tag, ".fwd1"}, ifc.fwd1_data, dv);
    model_fwd(ifc.rs2_addr, h, dv);
    chk({tag, ".hit2"}, DATA_W'(ifc.fwd2_hit), DATA_W'(h));
    chk({tag, ".fwd2"}, ifc.fwd2_data, dv);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".wen"},  DATA_W'(ifc.RegWEn_out), '0);
    chk({tag, ".addr"}, DATA_W'(ifc.AddrD_out), '0);
    chk({tag, ".data"}, ifc.DataD_out, '0);
    chk({tag, ".pend"}, DATA_W'(ifc.pend_cnt), '0);
    chk({tag, ".hit1"}, DATA_W'(ifc.fwd1_hit), '0);
    chk({tag, ".hit2"}, DATA_W'(ifc.fwd2_hit), '0);
    chk({tag, ".fwd1"}, ifc.fwd1_data, '0);
    chk({tag, ".fwd2"}, ifc.fwd2_data, '0);
  endtask

  task automatic set_in(input logic wen, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    ifc.RegWEn = wen;
    ifc.AddrD  = a;
    ifc.DataD  = d;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n = 1'b1;
    ifc.stall = 1'b0;
    ifc.flush = 1'b0;
    ifc.rs1_addr = '0;
    ifc.rs2_addr = '0;
    set_in(1'b0, '0, '0);
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_zero("reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check_all("idle");

    // Single write to x3, tracked through exit
    ifc.rs1_addr = 5'd3;
    set_in(1'b1, 5'd3, 32'hDEAD_BEEF);
    step("w3.cap");
    set_in(1'b0, '0, '0);
    step("w3.out");
    step("w3.exit");

    // Back-to-back writes to x7: youngest must win on forwarding
    ifc.rs1_addr = 5'd7;
    ifc.rs2_addr = 5'd7;
    set_in(1'b1, 5'd7, 32'h11);
    step("x7.a");
    set_in(1'b1, 5'd7, 32'h22);
    step("x7.b");
    set_in(1'b0, '0, '0);
    step("x7.c");
    step("x7.d");

    // Write to x0 is dropped
    ifc.rs1_addr = 5'd0;
    ifc.rs2_addr = 5'd0;
    set_in(1'b1, 5'd0, 32'hFFFF_FFFF);
    step("x0.a");
    set_in(1'b0, '0, '0);
    step("x0.b");
    step("x0.c");

    // Stall for three cycles with one entry in stage 0; input during stall lost
    ifc.rs1_addr = 5'd9;
    ifc.rs2_addr = 5'd10;
    set_in(1'b1, 5'd9, 32'hCAFE_0009);
    step("st.cap");
    ifc.stall = 1'b1;
    set_in(1'b1, 5'd10, 32'h0000_0010);
    for (int i = 0; i < 3; i++) step("st.hold");
    ifc.stall = 1'b0;
    set_in(1'b0, '0, '0);
    step("st.run");
    step("st.exit");

    // Two entries in flight, then flush together with stall
    ifc.rs1_addr = 5'd4;
    ifc.rs2_addr = 5'd5;
    set_in(1'b1, 5'd4, 32'h4444);
    step("fl.a");
    set_in(1'b1, 5'd5, 32'h5555);
    step("fl.b");
    ifc.flush = 1'b1;
    ifc.stall = 1'b1;
    set_in(1'b1, 5'd6, 32'h6666);
    step("fl.go");
    ifc.flush = 1'b0;
    ifc.stall = 1'b0;
    set_in(1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) step("fl.after");

    // Asynchronous reset mid-cycle with full stages
    set_in(1'b1, 5'd12, 32'h1212);
    step("ar.a");
    set_in(1'b1, 5'd13, 32'h1313);
    ifc.rs1_addr = 5'd12;
    ifc.rs2_addr = 5'd13;
    step("ar.b");
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_zero("ar.async");
    @(negedge clk);
    reset_n = 1'b1;
    set_in(1'b0, '0, '0);
    step("ar.post");

    // Random phase: small address range to provoke forwarding hits
    for (int i = 0; i < 400; i++) begin
      ifc.stall    = ($urandom_range(0, 5) == 0);
      ifc.flush    = ($urandom_range(0, 15) == 0);
      ifc.rs1_addr = ADDR_W'($urandom_range(0, 7));
      ifc.rs2_addr = ADDR_W'($urandom_range(0, 7));
      set_in(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
